fetch_unit: RTL and testbench

//  Instruction-fetch control stage between the program counter register and decode.

---
 rtl/fetch_unit_if.sv | 43 ++++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response and decode handoff.
// master = fetch side, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int PC_WIDTH = 32,
  parameter int INSTR_W  = 32
);
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [PC_WIDTH-1:0] imem_req_addr;
  logic                imem_rsp_valid;
  logic [INSTR_W-1:0]  imem_rsp_data;
  logic                if_valid;
  logic                if_ready;
  logic [INSTR_W-1:0]  if_instr;
  logic [PC_WIDTH-1:0] if_pc;
  logic                if_misalign;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output if_misalign
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  if_misalign
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: in-order fetch, pc pairing, decode FIFO, redirect flush.
// Option FETCH_MISALIGN_TRAP_EN: misaligned pc yields a marker entry.
module fetch_unit #(
  parameter int PC_WIDTH   = 32,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] pc_plus_4,
  output logic [PC_WIDTH-1:0] next_pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  fetch_unit_if.master        bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic                mis;
    logic [PC_WIDTH-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } ent_t;

  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fcount;
  logic [CW-1:0] credit;
  logic [AW-1:0] pwr, prd;
  logic [AW-1:0] fwr, frd;
  logic [PC_WIDTH-1:0] pq [FIFO_DEPTH];
  ent_t fq [FIFO_DEPTH];
  ent_t push_ent;

  logic can_issue;
  logic blocked;
  logic mark_push;
  logic req_hs;
  logic rsp;
  logic rsp_keep;
  logic push;
  logic pop;

  assign credit    = outstanding + fcount;
  assign can_issue = !rst && (credit < DEPTH_C);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trapped;
  logic mis_pc;
  logic pend_empty;

  assign mis_pc     = pc[1:0] != 2'b00;
  assign blocked    = mis_pc | trapped;
  // wait for live fetches to land so the marker stays in order
  assign pend_empty = outstanding == discard;
  assign mark_push  = can_issue & mis_pc & !trapped
                    & !redirect_valid & pend_empty;

  // Trap latch: one marker per misaligned target, cleared by redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 trapped <= 1'b0;
    else if (redirect_valid) trapped <= 1'b0;
    else if (mark_push)      trapped <= 1'b1;
  end
`else
  assign blocked   = 1'b0;
  assign mark_push = 1'b0;
`endif

  assign bus.imem_req_valid = can_issue & !redirect_valid & !blocked;
  assign bus.imem_req_addr  = pc;
  assign req_hs = bus.imem_req_valid & bus.imem_req_ready;

  assign next_pc = redirect_valid ? redirect_pc :
                   req_hs         ? pc_plus_4   : pc;

  assign rsp      = bus.imem_rsp_valid;
  assign rsp_keep = rsp & (discard == '0) & !redirect_valid;
  assign push     = rsp_keep | mark_push;

  // Select FIFO entry: memory response or misalign marker
  always_comb begin
    push_ent.mis   = 1'b1;
    push_ent.pc    = pc;
    push_ent.instr = '0;
    if (rsp_keep) begin
      push_ent.mis   = 1'b0;
      push_ent.pc    = pq[prd];
      push_ent.instr = bus.imem_rsp_data;
    end
  end

  assign bus.if_valid    = (fcount != '0) & !redirect_valid;
  assign pop             = bus.if_valid & bus.if_ready;
  assign bus.if_instr    = fq[frd].instr;
  assign bus.if_pc       = fq[frd].pc;
  assign bus.if_misalign = fq[frd].mis;

  // In-flight count and stale responses to drop after a redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_hs) - CW'(rsp);
      if (redirect_valid)
        discard <= outstanding - CW'(rsp);
      else if (rsp && discard != '0)
        discard <= discard - CW'(1);
    end
  end

  // Pending-address queue pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwr <= '0;
      prd <= '0;
    end else if (redirect_valid) begin
      pwr <= '0;
      prd <= '0;
    end else begin
      if (req_hs)   pwr <= pwr + AW'(1);
      if (rsp_keep) prd <= prd + AW'(1);
    end
  end

  // Pending-address storage
  always_ff @(posedge clk) begin
    if (req_hs) pq[pwr] <= pc;
  end

  // Decode FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwr    <= '0;
      frd    <= '0;
      fcount <= '0;
    end else if (redirect_valid) begin
      fwr    <= '0;
      frd    <= '0;
      fcount <= '0;
    end else begin
      if (push) fwr <= fwr + AW'(1);
      if (pop)  frd <= frd + AW'(1);
      fcount <= fcount + CW'(push) - CW'(pop);
    end
  end

  // Decode FIFO storage
  always_ff @(posedge clk) begin
    if (push) fq[fwr] <= push_ent;
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random fetch traffic vs. a sequential-stream model.
// Scoreboard of expected {pc,instr}; monitor compares decode output.
module tb_fetch_unit;
  localparam int PW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MIS_OK = 1'b0;
`else
  localparam bit MIS_OK = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] pc;
  logic [PW-1:0] pc_plus_4;
  logic [PW-1:0] next_pc;
  logic          redirect_valid = 1'b0;
  logic [PW-1:0] redirect_pc = '0;

  fetch_unit_if #(.PC_WIDTH(PW), .INSTR_W(IW)) bus ();

  fetch_unit #(
    .PC_WIDTH(PW), .INSTR_W(IW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .pc_plus_4(pc_plus_4),
    .next_pc(next_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else     pc <= next_pc;
  end
  assign pc_plus_4 = pc + 32'd4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  typedef struct {
    int          due;
    logic [31:0] addr;
    int          ep;
  } mrsp_t;

  exp_t  sb_q[$];
  mrsp_t mem_q[$];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int lat_lo = 1;
  int lat_hi = 1;
  int last_due = -1;
  int buffered = 0;
  int epoch = 0;
  int hs_cnt = 0;
  bit chk_en = 1'b1;
  bit last_rv = 1'b0;
  logic [31:0] model_pc = '0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = 32'($urandom_range(0, 32'h0000_FFFF)) & 32'hFFFC;
    if (MIS_OK) t[1:0] = 2'($urandom_range(0, 3));
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // mode: 0 none, 1 redirect, 2 redirect if rsp now, 3 if 2 in flight
  task automatic step(input bit rdy, input bit ifr,
                      input int mode, input logic [31:0] rpc);
    bit rv;
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_req_ready = rdy;
    bus.if_ready       = ifr;
    redirect_pc        = rpc;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    case (mode)
      1:       rv = 1'b1;
      2:       rv = bus.imem_rsp_valid;
      3:       rv = mem_q.size() == 2;
      default: rv = 1'b0;
    endcase
    redirect_valid = rv;
    last_rv        = rv;
  endtask

  task automatic mon_cycle();
    bit    hs;
    bit    rv;
    int    d;
    exp_t  e;
    mrsp_t m;
    rv = redirect_valid;
    hs = bus.imem_req_valid && bus.imem_req_ready;
    if (chk_en) begin
      check("next_pc", next_pc,
            rv ? redirect_pc : (hs ? pc + 32'd4 : pc));
      check("req_valid", 32'(bus.imem_req_valid),
            32'(!rv && (mem_q.size() + buffered < DEPTH)));
      check("if_valid", 32'(bus.if_valid),
            32'(!rv && buffered > 0));
      if (bus.imem_req_valid)
        check("req_addr", bus.imem_req_addr, model_pc);
    end
    if (hs) begin
      d = cyc + $urandom_range(lat_lo, lat_hi);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mem_q.push_back('{due: d, addr: model_pc, ep: epoch});
      sb_q.push_back('{pc: model_pc, instr: mem_word(model_pc)});
      hs_cnt++;
      model_pc += 32'd4;
    end
    if (bus.if_valid && bus.if_ready) begin
      if (sb_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_instr: got pc %h want none",
                 bus.if_pc);
      end else begin
        e = sb_q.pop_front();
        if (chk_en) begin
          check("if_pc", bus.if_pc, e.pc);
          check("if_instr", bus.if_instr, e.instr);
          check("if_misalign", 32'(bus.if_misalign), 32'd0);
        end
      end
      buffered--;
    end
    if (bus.imem_rsp_valid && mem_q.size() > 0) begin
      m = mem_q.pop_front();
      if (!rv && m.ep == epoch) buffered++;
    end
    if (rv) begin
      sb_q.delete();
      buffered = 0;
      epoch++;
      model_pc = redirect_pc;
    end
  endtask

  always begin
    @(posedge clk);
    #3;
    if (!rst) mon_cycle();
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int  hits;
    int  cool;
    bit  seen;
    bus.imem_req_ready = 1'b0;
    bus.if_ready       = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    repeat (2) step(1'b1, 1'b1, 0, 32'h0);
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_next_pc", next_pc, 32'h0);

    lat_lo = 1;
    lat_hi = 1;
    step(1'b1, 1'b1, 0, 32'h0);
    rst = 1'b0;
    #1;
    check("t1_if_valid_c0", 32'(bus.if_valid), 32'd0);
    step(1'b1, 1'b1, 0, 32'h0);
    #1;
    check("t1_if_valid_c1", 32'(bus.if_valid), 32'd0);
    step(1'b1, 1'b1, 0, 32'h0);
    #1;
    check("t1_if_valid_c2", 32'(bus.if_valid), 32'd1);
    check("t1_first_pc", bus.if_pc, 32'h0);
    repeat (20) step(1'b1, 1'b1, 0, 32'h0);

    step(1'b1, 1'b0, 1, 32'h40);
    hs_cnt = 0;
    repeat (12) step(1'b1, 1'b0, 0, 32'h0);
    #1;
    check("t2_req_count", 32'(hs_cnt), 32'(DEPTH));
    check("t2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("t2_next_pc", next_pc, 32'h48);

    lat_lo = 3;
    lat_hi = 3;
    step(1'b1, 1'b1, 1, 32'h80);
    last_rv = 1'b0;
    for (int k = 0; k < 20 && !last_rv; k++)
      step(1'b1, 1'b1, 3, 32'h100);
    check("t3_redirect_hit", 32'(last_rv), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1'b1, 1'b1, 0, 32'h0);
      #1;
      if (bus.if_valid) begin
        seen = 1'b1;
        check("t3_first_pc", bus.if_pc, 32'h100);
      end
    end
    check("t3_seen", 32'(seen), 32'd1);

    lat_lo = 2;
    lat_hi = 3;
    hits = 0;
    cool = 0;
    for (int k = 0; k < 200 && hits < 3; k++) begin
      step(1'b1, 1'b1, (cool == 0) ? 2 : 0, rand_tgt());
      if (last_rv) begin
        hits++;
        cool = 6;
      end else if (cool > 0) begin
        cool--;
      end
    end
    check("t4_rsp_redirects", 32'(hits), 32'd3);

    lat_lo = 1;
    lat_hi = 2;
    for (int k = 0; k < 40; k++)
      step(k % 2 == 0, 1'b1, 0, 32'h0);

    lat_lo = 1;
    lat_hi = 4;
    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0,
           ($urandom_range(0, 11) == 0) ? 1 : 0,
           rand_tgt());

`ifdef FETCH_MISALIGN_TRAP_EN
    chk_en = 1'b0;
    step(1'b1, 1'b0, 1, 32'h102);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, 0, 32'h0);
      #1;
      check("t6_no_req", 32'(bus.imem_req_valid), 32'd0);
      check("t6_next_pc", next_pc, 32'h102);
      if (bus.if_valid && !seen) begin
        seen = 1'b1;
        check("t6_misalign", 32'(bus.if_misalign), 32'd1);
        check("t6_pc", bus.if_pc, 32'h102);
        check("t6_instr", bus.if_instr, 32'h0);
      end
    end
    check("t6_marker_seen", 32'(seen), 32'd1);
    step(1'b1, 1'b1, 1, 32'h200);
    chk_en = 1'b1;
    hs_cnt = 0;
    repeat (5) step(1'b1, 1'b1, 0, 32'h0);
    check("t6_resume", 32'(hs_cnt != 0), 32'd1);
`endif

    repeat (12) step(1'b1, 1'b1, 0, 32'h0);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end
endmodule
